// File: rtl/alu_ext_pkg.sv
// Shared definitions for the sequential operand-extender ALU: op codes,
// FSM states and operand-B conditioning.
package alu_ext_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Conditions one bit of B and yields {opB bit, cin}; applied bit-wise so any width works.
  function automatic logic [1:0] cond_opb(input logic [1:0] s, input logic b);
    case (s)
      OP_ADD:  return {b, 1'b0};
      OP_SUB:  return {~b, 1'b1};
      OP_INC:  return {1'b0, 1'b1};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/alu_ext_seq_if.sv
// Request/result bus between the sequencer, the ALU and the result bus.
interface alu_ext_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       s;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic [WIDTH-1:0] acc_q;

  modport master (
    output in_valid, a, b, s, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, acc_q
  );

  modport slave (
    input  in_valid, a, b, s, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, acc_q
  );
endinterface

// File: rtl/alu_ext_slice.sv
// Combinational CHUNK-bit adder slice, time-multiplexed by the top level.
module alu_ext_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             zero
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign zero = (sum == '0);
endmodule

// File: rtl/alu_ext_seq.sv
// Multi-cycle ALU: conditions B, adds CHUNK bits per cycle with a registered
// carry, then presents result, flags and accumulator with valid/ready.
module alu_ext_seq
  import alu_ext_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_ext_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("alu_ext_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, work, result_r, acc_r;
  logic [CW-1:0]    slice;
  logic             carry, z_acc, a_msb, b_msb;
  logic             in_ready_r, out_valid_r, c_r, z_r, n_r, v_r;

  logic [WIDTH-1:0] opa_sel, opb_cond, work_next;
  logic             cin_cond;
  logic [CHUNK-1:0] sum;
  logic             cout, zero;

  alu_ext_slice #(.CHUNK(CHUNK)) u_slice (
    .x   (op_a[CHUNK-1:0]),
    .y   (op_b[CHUNK-1:0]),
    .cin (carry),
    .sum (sum),
    .cout(cout),
    .zero(zero)
  );

  always_comb begin
    opa_sel  = bus.acc_sel ? acc_r : bus.a;
    opb_cond = '0;
    cin_cond = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      {opb_cond[i], cin_cond} = cond_opb(bus.s, bus.b[i]);
    end
    // Slices arrive LSB first, so each new sum enters at the top of the word.
    work_next = (work >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      work        <= '0;
      result_r    <= '0;
      acc_r       <= '0;
      slice       <= '0;
      carry       <= 1'b0;
      z_acc       <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      c_r         <= 1'b0;
      z_r         <= 1'b0;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a       <= opa_sel;
            op_b       <= opb_cond;
            carry      <= cin_cond;
            a_msb      <= opa_sel[WIDTH-1];
            b_msb      <= opb_cond[WIDTH-1];
            z_acc      <= 1'b1;
            slice      <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          carry <= cout;
          z_acc <= z_acc & zero;
          work  <= work_next;
          slice <= slice + 1'b1;
          if (slice == CW'(NSLICE - 1)) begin
            result_r    <= work_next;
            c_r         <= cout;
            z_r         <= z_acc & zero;
            n_r         <= sum[CHUNK-1];
            v_r         <= (a_msb == b_msb) & (sum[CHUNK-1] != a_msb);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_r       <= result_r;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A clear takes priority over the handshake load.
      if (bus.acc_clr) acc_r <= '0;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flag_c    = c_r;
  assign bus.flag_z    = z_r;
  assign bus.flag_n    = n_r;
  assign bus.flag_v    = v_r;
  assign bus.acc_q     = acc_r;
endmodule
